// File: rtl/dispatch_lane_arbiter.sv
// ============================================================================
// Module      : dispatch_lane_arbiter
// Description : Round-robin arbiter sharing one registered dispatch port among
//               NUM_REQS issue slices, with lock-through of vector sequences.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dispatch_lane_arbiter #(
    parameter int NUM_REQS   = 4,
    parameter int DATA_WIDTH = 256,
    localparam int SEL_W     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            req_valid,
    input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQS-1:0]            req_lock,
    input  logic [NUM_REQS-1:0]            req_last,
    output logic [NUM_REQS-1:0]            req_ready,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]               out_sel,
    input  logic                           out_ready,
    output logic                           locked,
    output logic [31:0]                    stall_cnt
);

    localparam logic [SEL_W:0]   c_NUM_EXT = (SEL_W+1)'(NUM_REQS);
    localparam logic [SEL_W-1:0] c_LAST_IDX = SEL_W'(NUM_REQS - 1);

    logic [SEL_W-1:0]      r_rr_ptr;
    logic                  r_locked;
    logic [SEL_W-1:0]      r_lock_idx;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0]      r_out_sel;
    logic [31:0]           r_stall_cnt;

    logic [DATA_WIDTH-1:0] w_req_data [NUM_REQS];
    logic                  w_any_grant;
    logic [SEL_W-1:0]      w_grant_idx;
    logic [SEL_W:0]        w_sum;
    logic [SEL_W-1:0]      w_cand;
    logic                  w_can_load;
    logic                  w_load;
    logic                  w_opens_lock;
    logic [SEL_W-1:0]      w_next_ptr;

    generate
        for (genvar i = 0; i < NUM_REQS; i++) begin : g_unpack
            assign w_req_data[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            assign req_ready[i]  = !reset && w_load && (w_grant_idx == SEL_W'(i));
        end
    endgenerate

    // Offsets are scanned from farthest to nearest so the last hit is the
    // nearest valid requester at or after the round-robin pointer.
    always_comb begin
        w_any_grant = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        w_cand      = '0;
        if (r_locked) begin
            w_any_grant = req_valid[r_lock_idx];
            w_grant_idx = r_lock_idx;
        end else begin
            for (int k = NUM_REQS - 1; k >= 0; k--) begin
                w_sum = {1'b0, r_rr_ptr} + (SEL_W+1)'(k);
                if (w_sum >= c_NUM_EXT) begin
                    w_sum = w_sum - c_NUM_EXT;
                end
                w_cand = w_sum[SEL_W-1:0];
                if (req_valid[w_cand]) begin
                    w_any_grant = 1'b1;
                    w_grant_idx = w_cand;
                end
            end
        end
    end

    assign w_can_load   = !r_out_valid || out_ready;
    assign w_load       = w_can_load && w_any_grant;
    assign w_opens_lock = req_lock[w_grant_idx] && !req_last[w_grant_idx];
    assign w_next_ptr   = (w_grant_idx == c_LAST_IDX) ? '0 : w_grant_idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_locked    <= 1'b0;
            r_lock_idx  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_out_valid && !out_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_req_data[w_grant_idx];
                r_out_sel   <= w_grant_idx;
                if (w_opens_lock) begin
                    r_locked   <= 1'b1;
                    r_lock_idx <= w_grant_idx;
                end else begin
                    r_locked <= 1'b0;
                    r_rr_ptr <= w_next_ptr;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign locked    = r_locked;
    assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dispatch_lane_arbiter.sv
// ============================================================================
// Module      : tb_dispatch_lane_arbiter
// Description : Self-checking bench: vector table, corner sequences and random
//               traffic compared against a behavioural arbiter model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dispatch_lane_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_lock, req_last, req_ready;
    logic [N*DW-1:0] req_data;
    logic            out_valid, out_ready, locked;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_sel;
    logic [31:0]     stall_cnt;

    dispatch_lane_arbiter #(.NUM_REQS(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data),
        .req_lock(req_lock), .req_last(req_last), .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready), .locked(locked), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Behavioural model state
    int          m_ptr, m_idx, m_os;
    bit          m_locked, m_ov;
    logic [DW-1:0] m_od;
    logic [31:0] m_stall;

    typedef struct {
        logic [N-1:0] v, lk, ls;
        logic         ordy;
        int           sel;
        bit           ov, lkd;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic m_reset();
        m_ptr = 0; m_idx = 0; m_os = 0; m_locked = 0; m_ov = 0; m_od = '0; m_stall = '0;
    endtask

    function automatic int m_grant();
        if (m_locked) return req_valid[m_idx] ? m_idx : -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic m_check();
        int g;
        logic [N-1:0] exp_rdy;
        g = m_grant();
        exp_rdy = (g >= 0 && (!m_ov || out_ready)) ? N'(1 << g) : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_sel",   64'(out_sel),   64'(m_os));
        chk("out_data",  64'(out_data),  64'(m_od));
        chk("locked",    64'(locked),    64'(m_locked));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    endtask

    task automatic m_update();
        int g;
        g = m_grant();
        if (m_ov && !out_ready) m_stall++;
        if (g >= 0 && (!m_ov || out_ready)) begin
            m_od = req_data[g*DW +: DW];
            m_os = g;
            m_ov = 1;
            if (req_lock[g] && !req_last[g]) begin
                m_locked = 1; m_idx = g;
            end else begin
                m_locked = 0; m_ptr = (g + 1) % N;
            end
        end else if (m_ov && out_ready) begin
            m_ov = 0;
        end
    endtask

    // Called just after a negedge with inputs applied; returns at the next negedge.
    task automatic cycle();
        #1;
        m_check();
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] lk,
                         input logic [N-1:0] ls, input logic r);
        req_valid = v; req_lock = lk; req_last = ls; out_ready = r;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
    endtask

    initial begin
        logic [31:0]   s0;
        logic [DW-1:0] held;

        tbl[0]  = '{4'hF, 4'h0, 4'h0, 1'b1, 0, 1, 0};
        tbl[1]  = '{4'hF, 4'h0, 4'h0, 1'b1, 1, 1, 0};
        tbl[2]  = '{4'hF, 4'h0, 4'h0, 1'b1, 2, 1, 0};
        tbl[3]  = '{4'hF, 4'h0, 4'h0, 1'b1, 3, 1, 0};
        tbl[4]  = '{4'hF, 4'h0, 4'h0, 1'b1, 0, 1, 0};
        tbl[5]  = '{4'hF, 4'h2, 4'h0, 1'b1, 1, 1, 1};
        tbl[6]  = '{4'hF, 4'h2, 4'h0, 1'b1, 1, 1, 1};
        tbl[7]  = '{4'hF, 4'h2, 4'h0, 1'b1, 1, 1, 1};
        tbl[8]  = '{4'hF, 4'h2, 4'h2, 1'b1, 1, 1, 0};
        tbl[9]  = '{4'hF, 4'h0, 4'h0, 1'b1, 2, 1, 0};
        tbl[10] = '{4'hF, 4'h0, 4'h0, 1'b1, 3, 1, 0};

        reset = 1'b1;
        drive(4'hF, 4'h0, 4'h0, 1'b1);
        m_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_locked",    64'(locked),    64'h0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(4'h0, 4'h0, 4'h0, 1'b1);
        cycle();

        // Table: rotation, then a 4-beat vector from req1 amid contention
        for (int t = 0; t < 11; t++) begin
            drive(tbl[t].v, tbl[t].lk, tbl[t].ls, tbl[t].ordy);
            cycle();
            chk($sformatf("tbl%0d_sel", t),    64'(out_sel),   64'(tbl[t].sel));
            chk($sformatf("tbl%0d_valid", t),  64'(out_valid), 64'(tbl[t].ov));
            chk($sformatf("tbl%0d_locked", t), 64'(locked),    64'(tbl[t].lkd));
        end

        // Backpressure: 5 stalled cycles, then release with same-cycle reload
        drive(4'hF, 4'h0, 4'h0, 1'b0);
        #1;
        s0   = stall_cnt;
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_ready", 64'(req_ready), 64'h0);
            chk("stall_data",  64'(out_data),  64'(held));
            cycle();
        end
        chk("stall_delta", 64'(stall_cnt - s0), 64'd5);
        out_ready = 1'b1;
        cycle();
        chk("release_valid", 64'(out_valid), 64'h1);

        // Locked req3 drops valid for 3 cycles while req0 waits
        drive(4'h8, 4'h8, 4'h0, 1'b1);
        cycle();
        chk("lock3_set", 64'(locked), 64'h1);
        for (int i = 0; i < 3; i++) begin
            drive(4'h1, 4'h8, 4'h0, 1'b1);
            #1;
            chk("lock3_block", 64'(req_ready), 64'h0);
            cycle();
            chk("lock3_drain", 64'(out_valid), 64'h0);
            chk("lock3_hold",  64'(locked),    64'h1);
        end
        drive(4'h9, 4'h8, 4'h8, 1'b1);
        cycle();
        chk("lock3_resume_sel", 64'(out_sel), 64'd3);
        chk("lock3_released",   64'(locked),  64'h0);

        // Single-beat vector from req2 never locks; pointer moves to 3
        drive(4'h4, 4'h4, 4'h4, 1'b1);
        cycle();
        chk("sbv_sel",    64'(out_sel), 64'd2);
        chk("sbv_locked", 64'(locked),  64'h0);
        drive(4'hF, 4'h0, 4'h0, 1'b1);
        cycle();
        chk("sbv_next_sel", 64'(out_sel), 64'd3);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(N'($urandom), N'($urandom) & N'($urandom), N'($urandom),
                  ($urandom_range(0, 3) != 0));
            cycle();
        end

        // Asynchronous reset mid-stream
        drive(4'hF, 4'h4, 4'h0, 1'b0);
        cycle();
        #2;
        reset = 1'b1;
        #1;
        m_reset();
        chk("arst_valid",  64'(out_valid), 64'h0);
        chk("arst_data",   64'(out_data),  64'h0);
        chk("arst_sel",    64'(out_sel),   64'h0);
        chk("arst_locked", 64'(locked),    64'h0);
        chk("arst_stall",  64'(stall_cnt), 64'h0);
        chk("arst_ready",  64'(req_ready), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            drive(N'($urandom), N'($urandom) & N'($urandom), N'($urandom),
                  ($urandom_range(0, 3) != 0));
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
